// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - N-channel debouncer with press/release/level outputs.
// Define BUTTON_DEBOUNCER_AUTOREPEAT_EN to add hold-to-repeat ticks on pulse.
module button_debouncer #(
   parameter int CHANNELS      = 8,
   parameter int STABLE_CYCLES = 250000,
   parameter int ACTIVE_HIGH   = 1,
   parameter int REPEAT_DELAY  = 12500000,
   parameter int REPEAT_PERIOD = 2500000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] stable,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] pulse,
   output logic                any_press
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CHANNELS-1:0] IN_INVERT = (ACTIVE_HIGH == 0) ? '1 : '0;

   if (CHANNELS < 1 || STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("button_debouncer: illegal parameter value");
   end

   logic [CHANNELS-1:0]         sync1_q, sync1_d;
   logic [CHANNELS-1:0]         sync2_q, sync2_d;
   logic [CHANNELS-1:0]         stable_q, stable_d;
   logic [CHANNELS-1:0]         press_q, press_d;
   logic [CHANNELS-1:0]         release_q, release_d;
   logic [CHANNELS-1:0]         pulse_q, pulse_d;
   logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;
   logic [CHANNELS-1:0]         norm;

   always_comb begin
      sync1_d   = in;
      sync2_d   = sync1_q;
      norm      = sync2_q ^ IN_INVERT;
      stable_d  = stable_q;
      press_d   = '0;
      release_d = '0;
      cnt_d     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         // Any sample matching the accepted level leaves the counter at zero.
         if (norm[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i]  = norm[i];
               press_d[i]   = norm[i];
               release_d[i] = ~norm[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = $clog2(RMAX + 1);
   localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

   logic [CHANNELS-1:0][HW-1:0] hold_q, hold_d;
   logic [CHANNELS-1:0]         rep_q, rep_d;
   logic [CHANNELS-1:0]         tick;

   always_comb begin
      hold_d = '0;
      rep_d  = '0;
      tick   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         // A release accepted this edge wins over a tick due on the same edge.
         if (stable_q[i] && !release_d[i]) begin
            if (hold_q[i] == (rep_q[i] ? PER_LAST : DLY_LAST)) begin
               tick[i]  = 1'b1;
               rep_d[i] = 1'b1;
            end else begin
               hold_d[i] = hold_q[i] + HW'(1);
               rep_d[i]  = rep_q[i];
            end
         end
      end
      pulse_d = press_d | tick;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= '0;
         rep_q  <= '0;
      end else begin
         hold_q <= hold_d;
         rep_q  <= rep_d;
      end
   end
`else
   always_comb begin
      pulse_d = press_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         stable_q  <= '0;
         press_q   <= '0;
         release_q <= '0;
         pulse_q   <= '0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         stable_q  <= stable_d;
         press_q   <= press_d;
         release_q <= release_d;
         pulse_q   <= pulse_d;
         cnt_q     <= cnt_d;
      end
   end

   assign stable        = stable_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign pulse         = pulse_q;
   assign any_press     = |press_q;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Parametrised N-channel debouncer and edge detector for front-panel buttons and NES controller lines, in the pixel-clock domain ahead of the image/UI logic.
- Generalises the fixed 3- and 8-input debouncers to any channel count, configurable settle time and input polarity.
- Adds per-channel press and release pulses, a level output and an any-press strobe.
- Optional hold-to-repeat for menu navigation.

Parameters:
- CHANNELS, 8: number of independent input channels (≥1).
- STABLE_CYCLES, 250000: clocks an input must hold a new level before it is accepted (≥2); 250000 ≈ 10 ms at the pixel clock.
- ACTIVE_HIGH, 1: 1 = raw input high means pressed; 0 = raw input low means pressed (normalised internally).
- REPEAT_DELAY, 12500000: clocks from press pulse to first repeat tick (auto-repeat builds only; ≥1).
- REPEAT_PERIOD, 2500000: clocks between subsequent repeat ticks (auto-repeat builds only; ≥1).

Ports:
- clk  input  1  pixel clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in  input  CHANNELS  raw asynchronous button inputs.
- stable  output  CHANNELS  debounced level, 1 = pressed.
- press  output  CHANNELS  one-cycle pulse on accepted press.
- release  output  CHANNELS  one-cycle pulse on accepted release.
- pulse  output  CHANNELS  action strobe: press, or press plus repeat ticks when auto-repeat is built in.
- any_press  output  1  OR-reduction of press.

Behaviour:
- Reset: rst_n sampled low at a rising edge clears every register.
  - stable, press, release and pulse go to 0.
  - Synchronisers, settle counters and repeat counters go to 0.
  - The inactive level is the reset state.
- Synchronisation: per-channel two-flop synchroniser, then normalisation: n = sync2 XOR (ACTIVE_HIGH==0).
- Settle counter: per channel, width $clog2(STABLE_CYCLES+1).
  - If n == stable: counter cleared to 0.
  - Else counter increments.
  - When counter == STABLE_CYCLES-1 and n != stable: stable <= n, counter <= 0.
  - In the same edge, press <= n or release <= ~n.
- Latency: with in changed before edge 0 and held, stable and press/release are registered on edge STABLE_CYCLES+1, i.e. the (STABLE_CYCLES+2)th edge, and are visible after it.
- Pulses: press and release last exactly one cycle and are never both high on a channel.
  - Outputs are registered.
  - any_press is combinational from the registered press.
- Glitch rejection: any return of n to the stable level before the count completes clears the counter; no output change, no pulse.
- Independence: channels share nothing but clk/rst_n. Simultaneous presses on several channels all pulse in the same cycle; any_press is high for that one cycle.
- Reset mid-operation: in-flight counts are discarded and no pulse is generated on reset. A button held through reset is re-debounced from zero and produces press STABLE_CYCLES+2 edges after rst_n rises.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_AUTOREPEAT_EN.
- Defined: each channel has a hold counter, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
  - Cleared on press and whenever stable==0.
  - While stable==1 it counts; the first repeat tick fires REPEAT_DELAY cycles after the press cycle, then every REPEAT_PERIOD cycles.
  - Each tick is a one-cycle high on pulse only, never on press or any_press.
  - Release stops ticks immediately; a tick coinciding with release is suppressed.
- Not defined: no hold counters; pulse = press exactly.
- Port list is identical in both builds.

Test Plan:
1. Reset: STABLE_CYCLES=4, CHANNELS=3. Hold rst_n=0 for 3 cycles with in=3'b111 → all outputs 0. Release reset → press=3'b111 and any_press=1 on the 6th edge after reset deasserts; stable=3'b111 thereafter.
2. Glitch: STABLE_CYCLES=4. in[0] high for 3 cycles then low → stable[0], press[0] and pulse[0] stay 0 throughout.
3. Press/release timing: STABLE_CYCLES=4. in[1] rises at cycle 10 and falls at cycle 30 → press[1] high only in cycle 16; release[1] high only in cycle 36; stable[1] high over cycles 16–35.
4. Polarity: ACTIVE_HIGH=0, STABLE_CYCLES=4. in[2] driven 1→0 and held → press[2] one cycle after 6 edges; stable[2]=1.
5. Simultaneous and reset mid-count: channels 0 and 2 rise together → press=3'b101 in one cycle. Separately, rst_n pulsed low during a count → no pulse, and the count restarts from 0.
6. Auto-repeat (macro defined): STABLE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3. Press held → pulse at press cycle P, then P+8, P+11, P+14; press only at P. Release before P+17 → no further pulses.
